// File: rtl/shift_add_mul16_pkg.sv
// Shared widths, state encodings and register bundle for the
// shift-and-add multiplier.
package shift_add_mul16_pkg;

    localparam int MUL_W  = 16;
    localparam int PROD_W = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic [MUL_W-1:0] mcand;
        logic [MUL_W-1:0] hi;
        logic [MUL_W-1:0] lo;
    } mul_regs_t;

    function automatic logic is_zero_op(
        input logic [MUL_W-1:0] a,
        input logic [MUL_W-1:0] b
    );
        return (a == '0) || (b == '0);
    endfunction

endpackage

// File: rtl/shift_add_mul16_adder16.sv
// 16-bit ripple adder with carry in/out; the multiplier's add datapath.
module adder16
    import shift_add_mul16_pkg::*;
(
    input  logic [MUL_W-1:0] a,
    input  logic [MUL_W-1:0] b,
    input  logic             cin,
    output logic [MUL_W-1:0] s,
    output logic             cout
);

    assign {cout, s} = (MUL_W+1)'(a) + (MUL_W+1)'(b) + (MUL_W+1)'(cin);

endmodule

// File: rtl/shift_add_mul16.sv
// Multi-cycle 16x16 unsigned shift-and-add multiplier, one op in flight,
// one adder pass per iteration, valid/ready on both sides.
module shift_add_mul16
    import shift_add_mul16_pkg::*;
#(
    parameter int ZERO_BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    mul_regs_t         regs_q, regs_d;
    logic [PROD_W-1:0] product_q, product_d;
    logic              out_valid_q, out_valid_d;

    logic [MUL_W-1:0]  add_b;
    logic [MUL_W-1:0]  add_s;
    logic              add_co;

    assign add_b = regs_q.lo[0] ? regs_q.mcand : '0;

    adder16 u_adder (
        .a    (regs_q.hi),
        .b    (add_b),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_co)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        regs_d      = regs_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    regs_d.mcand = a;
                    regs_d.hi    = '0;
                    regs_d.lo    = b;
                    cnt_d        = '0;
                    if (ZERO_BYPASS != 0 && is_zero_op(a, b)) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        product_d   = '0;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Carry-out lands in hi[15]; the adder LSB shifts into lo.
                regs_d.hi = {add_co, add_s[MUL_W-1:1]};
                regs_d.lo = {add_s[0], regs_q.lo[MUL_W-1:1]};
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    product_d   = {add_co, add_s, regs_q.lo[MUL_W-1:1]};
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            regs_q      <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            regs_q      <= regs_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_shift_add_mul16.sv
// Scoreboard bench: driver pushes a*b expectations, monitor pops on
// each new product and checks latency, stability and handshake rules.
module tb_shift_add_mul16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        out_ready;
    logic        in_ready, out_valid, busy;
    logic [31:0] product;

    logic        in_valid0 = 1'b0;
    logic [15:0] a0 = '0, b0 = '0;
    logic        out_ready0 = 1'b0;
    logic        in_ready0, out_valid0, busy0;
    logic [31:0] product0;

    shift_add_mul16 #(.ZERO_BYPASS(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    shift_add_mul16 #(.ZERO_BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(out_ready0),
        .product(product0), .busy(busy0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] prod;
        int          e0;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // 0: always ready, 1: random backpressure, 2: never ready
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    initial out_ready = 1'b1;

    logic        ov_prev = 1'b0, or_prev = 1'b0;
    logic [31:0] prod_prev = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ov_prev = 1'b0;
            or_prev = 1'b0;
        end else begin
            if (ov_prev && !or_prev) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_product", product, prod_prev);
            end
            if (ov_prev && or_prev) begin
                chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
                chk("post_hs_ready", {31'd0, in_ready}, 32'd1);
                chk("post_hs_product", product, prod_prev);
            end
            if (out_valid && !(ov_prev && !or_prev)) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", product, 32'hxxxx_xxxx);
                end else begin
                    e = q.pop_front();
                    chk("product", product, e.prod);
                    chk("latency", 32'(cyc - e.e0), 32'(e.lat));
                    chk("busy_done", {31'd0, busy}, 32'd1);
                end
            end
            ov_prev   = out_valid;
            or_prev   = out_ready;
            prod_prev = product;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        e.prod = 32'(x) * 32'(y);
        e.e0   = cyc + 1;
        e.lat  = (x == 16'd0 || y == 16'd0) ? 0 : 16;
        q.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [15:0] x, input logic [15:0] y);
        wait_ready();
        in_valid = 1'b1;
        a = x;
        b = y;
        push_exp(x, y);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 3000) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int e0;
        int n;
        logic [15:0] x, y;

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_product", product, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Without bypass a zero operand still runs the full iteration.
        in_valid0 = 1'b1;
        a0 = 16'h0000;
        b0 = 16'h1234;
        tick();
        e0 = cyc;
        in_valid0 = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (out_valid0) break;
            n++;
        end
        chk("zb0_latency", 32'(cyc - e0), 32'd16);
        chk("zb0_product", product0, 32'd0);
        tick();
        out_ready0 = 1'b1;
        tick();
        chk("zb0_idle", {31'd0, in_ready0}, 32'd1);

        rdy_mode = 0;
        issue(16'd3, 16'd5);
        issue(16'hFFFF, 16'hFFFF);
        issue(16'h0000, 16'h1234);
        issue(16'h1234, 16'h0000);
        drain();

        // Backpressure, with a competing request that must be ignored.
        rdy_mode = 2;
        tick();
        issue(16'h8000, 16'h0002);
        wait_out_valid();
        in_valid = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        repeat (5) tick();
        in_valid = 1'b0;
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        rdy_mode = 0;
        drain();

        // Valid held high with changing operands during RUN.
        wait_ready();
        in_valid = 1'b1;
        a = 16'h00FF;
        b = 16'h0101;
        push_exp(16'h00FF, 16'h0101);
        tick();
        repeat (10) begin
            a = 16'($urandom);
            b = 16'($urandom);
            tick();
        end
        in_valid = 1'b0;
        drain();

        // Reset sampled at the eighth RUN edge.
        issue(16'h1234, 16'h5678);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_product", product, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        issue(16'd7, 16'd9);
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            if ($urandom_range(0, 7) == 0) x = 16'd0;
            if ($urandom_range(0, 7) == 0) y = 16'd0;
            if ($urandom_range(0, 9) == 0) x = 16'hFFFF;
            issue(x, y);
            repeat ($urandom_range(0, 2)) tick();
        end
        rdy_mode = 0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
